// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter among NUM_REQ byte streams.
// Optional build macro UART_ARB_PREFIX_EN prepends an ASCII requester id byte ('0'+g) to each packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    input  logic                 tx_busy,
    output logic                 timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

    localparam logic [2:0] ST_ARB   = 3'd0;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
`ifdef UART_ARB_PREFIX_EN
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_FIRST = ST_HDR;
`else
    localparam logic [2:0] ST_FIRST = ST_SEND;
`endif

    logic [2:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic             last_flag;
    logic [CNT_W-1:0] idle_cnt;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] next_rr;
    logic             owner_req;
    logic             owner_last;
    logic [7:0]       owner_byte;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner == IDX_W'(k)) begin
                owner_req  = req[k];
                owner_last = req_last[k];
                owner_byte = req_data[8*k +: 8];
            end
        end
    end

    assign next_rr = wrap_add(owner, 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ARB;
            rr_ptr      <= '0;
            owner       <= '0;
            last_flag   <= 1'b0;
            idle_cnt    <= '0;
            ack         <= '0;
            grant       <= '0;
            tx_data     <= '0;
            tx_wr       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack         <= '0;
            tx_wr       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_ARB: begin
                    // The UART may still be shifting a byte abandoned by a reset.
                    if (pick_valid && !tx_busy) begin
                        owner     <= pick_idx;
                        grant     <= ONE << pick_idx;
                        last_flag <= 1'b0;
                        idle_cnt  <= '0;
                        state     <= ST_FIRST;
                    end
                end
`ifdef UART_ARB_PREFIX_EN
                ST_HDR: begin
                    if (!tx_busy) begin
                        tx_wr     <= 1'b1;
                        tx_data   <= 8'h30 + 8'(owner);
                        last_flag <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
`endif
                ST_SEND: begin
                    // A byte ready in the same cycle as the timeout wins over the timeout.
                    if (owner_req && !tx_busy) begin
                        tx_wr     <= 1'b1;
                        ack       <= grant;
                        tx_data   <= owner_byte;
                        last_flag <= owner_last;
                        idle_cnt  <= '0;
                        state     <= ST_GAP;
                    end else if (!owner_req) begin
                        if (idle_cnt == CNT_LIMIT) begin
                            grant       <= '0;
                            timeout_err <= 1'b1;
                            rr_ptr      <= next_rr;
                            idle_cnt    <= '0;
                            state       <= ST_ARB;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!tx_busy) begin
                        if (last_flag) begin
                            grant  <= '0;
                            rr_ptr <= next_rr;
                            state  <= ST_ARB;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule
